// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data RAM with byte-lane stores, plus a
// small MMIO block (free-running counter, compare/match, sticky error
// status with first-error address capture, irq enable). Reads are purely
// combinational; all state changes on the rising edge of clk.
module data_mem_responder #(
    parameter int RAM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  sel,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int IDX_W = $clog2(RAM_WORDS);

    // MMIO registers decoded on the word address (addr[31:2])
    localparam logic [29:0] COUNT_WORD   = 30'h3FFF_C000;
    localparam logic [29:0] CMP_WORD     = 30'h3FFF_C001;
    localparam logic [29:0] STATUS_WORD  = 30'h3FFF_C002;
    localparam logic [29:0] ERRADDR_WORD = 30'h3FFF_C003;
    localparam logic [29:0] CTRL_WORD    = 30'h3FFF_C004;

    // Only naturally aligned byte, halfword and word stores are accepted
    function automatic logic storeLegal(input logic [3:0] s, input logic [1:0] lo);
        case (s)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: storeLegal = 1'b1;
            4'b0011, 4'b1100:                   storeLegal = ~lo[0];
            4'b1111:                            storeLegal = (lo == 2'b00);
            default:                            storeLegal = 1'b0;
        endcase
    endfunction

    // Expand the 4 lane enables into a 32-bit bit mask
    function automatic logic [31:0] expandSel(input logic [3:0] s);
        expandSel = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    logic [31:0]      ram [RAM_WORDS];
    logic [31:0]      count;
    logic [31:0]      cmp;
    logic [31:0]      errAddr;
    logic [2:0]       status;
    logic             ctrlEn;

    logic [29:0]      wordAddr;
    logic [IDX_W-1:0] ramIdx;
    logic             ramHit;
    logic             isCount;
    logic             isCmp;
    logic             isStatus;
    logic             isErrAddr;
    logic             isCtrl;
    logic             mmioHit;
    logic             storeOk;
    logic             doStore;
    logic             legalStore;
    logic             misEvt;
    logic             unmapEvt;
    logic             matchEvt;
    logic             ramWe;
    logic [31:0]      laneMask;
    logic [2:0]       w1c;

    assign wordAddr   = addr[31:2];
    assign ramIdx     = addr[IDX_W+1:2];
    assign ramHit     = (addr >> (IDX_W + 2)) == 32'd0;
    assign isCount    = (wordAddr == COUNT_WORD);
    assign isCmp      = (wordAddr == CMP_WORD);
    assign isStatus   = (wordAddr == STATUS_WORD);
    assign isErrAddr  = (wordAddr == ERRADDR_WORD);
    assign isCtrl     = (wordAddr == CTRL_WORD);
    assign mmioHit    = isCount | isCmp | isStatus | isErrAddr | isCtrl;

    // Stores during reset are ignored entirely (no write, no error flag)
    assign storeOk    = storeLegal(sel, addr[1:0]);
    assign doStore    = memwrite & ~rst;
    assign legalStore = doStore & storeOk;
    assign misEvt     = doStore & ~storeOk;
    assign unmapEvt   = legalStore & ~ramHit & ~mmioHit;
    assign ramWe      = legalStore & ramHit;
    assign matchEvt   = (count == cmp);
    assign laneMask   = expandSel(sel);
    assign w1c        = (legalStore & isStatus) ? (wdata[2:0] & laneMask[2:0]) : 3'd0;

    // Combinational read mux: RAM word, MMIO register, or zero when unmapped
    always_comb begin
        rdata = 32'd0;
        if (ramHit)         rdata = ram[ramIdx];
        else if (isCount)   rdata = count;
        else if (isCmp)     rdata = cmp;
        else if (isStatus)  rdata = {29'd0, status};
        else if (isErrAddr) rdata = errAddr;
        else if (isCtrl)    rdata = {31'd0, ctrlEn};
    end

    // RAM byte-lane writes; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (ramWe) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) ram[ramIdx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Timer, status, error capture and irq registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 32'd0;
            cmp     <= 32'hFFFF_FFFF;
            status  <= 3'd0;
            errAddr <= 32'd0;
            ctrlEn  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            count <= count + 32'd1;
            if (legalStore && isCmp) cmp <= (cmp & ~laneMask) | (wdata & laneMask);
            if (legalStore && isCtrl && sel[0]) ctrlEn <= wdata[0];
            // New events OR in after the clear so a same-cycle set wins
            status <= (status & ~w1c) | {unmapEvt, misEvt, matchEvt};
            // Keep the first faulting address until both error flags are clear
            if ((misEvt || unmapEvt) && (status[2:1] == 2'b00)) errAddr <= addr;
            irq <= status[0] & ctrlEn;
        end
    end

endmodule
